// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and FSM state type for the data-memory
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LANES     = 4;
    localparam int BYTE_W    = 8;
    localparam int LANE_BITS = 2;   // byte-offset bits below the word index

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Request/response handshake bundle of the core data port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [WORD_W-1:0] req_addr_i;
    logic [WORD_W-1:0] req_wdata_i;
    logic [LANES-1:0]  req_wmask_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [WORD_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface
`default_nettype wire

// File: rtl/dmem_word_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_word_array
//  Description : Single-port, byte-lane-writable word array with registered
//                read data. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_en,
    input  wire logic              i_we,
    input  wire logic [LANES-1:0]  i_lane_mask,
    input  wire logic [IDX_W-1:0]  i_idx,
    input  wire logic [WORD_W-1:0] i_wdata,
    output logic      [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int n = 0; n < LANES; n++) begin
                    if (i_lane_mask[n]) begin
                        r_mem[i_idx][n*BYTE_W +: BYTE_W] <= i_wdata[n*BYTE_W +: BYTE_W];
                    end
                end
            end
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Target end of the core data port: one request at a time,
//                programmable wait states, one response per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus
);

    localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_cnt_init  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit         c_zero_wait = (WAIT_CYCLES == 0);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_we;
    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [LANES-1:0]    r_wmask;
    logic [3:0]          r_cnt;
    logic                r_acc;
    logic                r_acc_err;
    logic                r_acc_we;
    logic [WORD_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_access;
    logic                w_acc_we;
    logic [WORD_W-1:0]   w_acc_addr;
    logic [WORD_W-1:0]   w_acc_wdata;
    logic [LANES-1:0]    w_acc_wmask;
    logic [WORD_W:0]     w_offset;
    logic                w_acc_err;
    logic [c_idx_w-1:0]  w_idx;
    logic [WORD_W-1:0]   w_arr_rdata;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid_i;

    // With no wait states the access happens on the accepting edge itself,
    // so the array is fed straight from the request inputs.
    assign w_acc_we    = c_zero_wait ? bus.req_we_i    : r_we;
    assign w_acc_addr  = c_zero_wait ? bus.req_addr_i  : r_addr;
    assign w_acc_wdata = c_zero_wait ? bus.req_wdata_i : r_wdata;
    assign w_acc_wmask = c_zero_wait ? bus.req_wmask_i : r_wmask;
    assign w_access    = c_zero_wait ? w_accept
                                     : ((r_state == ST_WAIT) && !r_acc && (r_cnt == 4'd0));

    // 33-bit offset: the carry bit flags addresses below the base.
    assign w_offset  = {1'b0, w_acc_addr} - {1'b0, BASE_ADDR};
    assign w_acc_err = (w_acc_addr[LANE_BITS-1:0] != '0) || w_offset[WORD_W]
                    || ((w_offset[WORD_W-1:0] >> (c_idx_w + LANE_BITS)) != '0);
    assign w_idx     = c_idx_w'(w_offset[WORD_W-1:0] >> LANE_BITS);

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_array (
        .clk         (clk),
        .i_en        (w_access && !reset && !w_acc_err),
        .i_we        (w_acc_we),
        .i_lane_mask (w_acc_wmask),
        .i_idx       (w_idx),
        .i_wdata     (w_acc_wdata),
        .o_rdata     (w_arr_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)          w_state_next = ST_WAIT;
            ST_WAIT: if (r_acc)             w_state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i)   w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.req_we_i;
            r_addr  <= bus.req_addr_i;
            r_wdata <= bus.req_wdata_i;
            r_wmask <= bus.req_wmask_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_acc       <= 1'b0;
            r_acc_err   <= 1'b0;
            r_acc_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_access;
            if (w_accept) begin
                r_cnt <= c_cnt_init;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_acc_err <= w_acc_err;
                r_acc_we  <= w_acc_we;
            end
            // Array read data is registered on the access edge; the response
            // is captured one edge later.
            if (r_acc) begin
                r_rsp_rdata <= (r_acc_err || r_acc_we) ? '0 : w_arr_rdata;
                r_rsp_err   <= r_acc_err;
            end else if ((r_state == ST_RESP) && bus.rsp_ready_i) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o = (r_state == ST_IDLE);
    assign bus.rsp_valid_o = (r_state == ST_RESP);
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for three responder builds (1, 0 and 3
//                wait states) driven from a vector table and a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        int          dut;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  v_valid = '0;
    logic [2:0]  v_rdy = '0;
    logic        v_we = 1'b0;
    logic [31:0] v_addr = '0;
    logic [31:0] v_wdata = '0;
    logic [3:0]  v_mask = '0;

    logic [2:0]  w_req_ready;
    logic [2:0]  w_rsp_valid;
    logic [2:0]  w_rsp_err;
    logic [31:0] w_rsp_rdata [3];

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[$];
    int   c_lat [3] = '{2, 1, 4};

    always #5 clk = ~clk;

    dmem_responder_if bus0();
    dmem_responder_if bus1();
    dmem_responder_if bus2();

    assign bus0.req_valid_i = v_valid[0];
    assign bus1.req_valid_i = v_valid[1];
    assign bus2.req_valid_i = v_valid[2];
    assign bus0.rsp_ready_i = v_rdy[0];
    assign bus1.rsp_ready_i = v_rdy[1];
    assign bus2.rsp_ready_i = v_rdy[2];
    assign bus0.req_we_i = v_we;    assign bus1.req_we_i = v_we;    assign bus2.req_we_i = v_we;
    assign bus0.req_addr_i = v_addr;  assign bus1.req_addr_i = v_addr;  assign bus2.req_addr_i = v_addr;
    assign bus0.req_wdata_i = v_wdata; assign bus1.req_wdata_i = v_wdata; assign bus2.req_wdata_i = v_wdata;
    assign bus0.req_wmask_i = v_mask;  assign bus1.req_wmask_i = v_mask;  assign bus2.req_wmask_i = v_mask;

    assign w_req_ready = {bus2.req_ready_o, bus1.req_ready_o, bus0.req_ready_o};
    assign w_rsp_valid = {bus2.rsp_valid_o, bus1.rsp_valid_o, bus0.rsp_valid_o};
    assign w_rsp_err   = {bus2.rsp_err_o, bus1.rsp_err_o, bus0.rsp_err_o};
    assign w_rsp_rdata[0] = bus0.rsp_rdata_o;
    assign w_rsp_rdata[1] = bus1.rsp_rdata_o;
    assign w_rsp_rdata[2] = bus2.rsp_rdata_o;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1))
        u_dut_w1 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_2000), .WAIT_CYCLES(0))
        u_dut_w0 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3))
        u_dut_w3 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] m,
                                input logic [31:0] er, input logic ee, input int hold);
        vec_t v;
        v.dut = d; v.we = we; v.addr = a; v.wdata = wd; v.mask = m;
        v.exp_rdata = er; v.exp_err = ee; v.hold = hold;
        return v;
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_req(input vec_t v);
        int   d = v.dut;
        int   n = 0;
        int   lat = 0;
        exp_t e;
        sb.push_back('{v.exp_rdata, v.exp_err, c_lat[d]});
        while (w_req_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_timeout", 32'(n < 50), 32'd1);
        v_we = v.we; v_addr = v.addr; v_wdata = v.wdata; v_mask = v.mask;
        v_valid[d] = 1'b1;
        v_rdy[d] = (v.hold == 0);
        @(posedge clk); #1;
        v_valid[d] = 1'b0;
        do begin
            @(posedge clk); #1; lat++;
        end while (w_rsp_valid[d] !== 1'b1 && lat < 40);
        e = sb.pop_front();
        chk($sformatf("lat d%0d a%h", d, v.addr), 32'(lat), 32'(e.lat));
        chk($sformatf("rdata d%0d a%h", d, v.addr), w_rsp_rdata[d], e.rdata);
        chk($sformatf("err d%0d a%h", d, v.addr), 32'(w_rsp_err[d]), 32'(e.err));
        if (v.hold > 0) begin
            // A stray store is offered during backpressure and must be ignored.
            v_we = 1'b1; v_addr = v.addr & 32'hFFFF_FFFC; v_wdata = '0; v_mask = 4'hF;
            v_valid[d] = 1'b1;
            for (int k = 0; k < v.hold; k++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(w_rsp_valid[d]), 32'd1);
                chk("hold_rdata", w_rsp_rdata[d], e.rdata);
                chk("hold_req_ready", 32'(w_req_ready[d]), 32'd0);
            end
            v_valid[d] = 1'b0;
        end
        v_rdy[d] = 1'b1;
        @(posedge clk); #1;
        v_rdy[d] = 1'b0;
        chk("post_hs_valid", 32'(w_rsp_valid[d]), 32'd0);
        chk("post_hs_ready", 32'(w_req_ready[d]), 32'd1);
        if (v.hold > 0) begin
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                chk("no_stray_rsp", 32'(w_rsp_valid[d]), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        // 1 wait state, base 0, 1024 words
        vecs.push_back(mk(0, 1, 32'h4D0, 32'hDEADBEEF, 4'hF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h4D0, 32'h0000AA00, 4'h2, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADAAEF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h4D0, 32'hFFFFFFFF, 4'h0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADAAEF, 0, 0));
        vecs.push_back(mk(0, 0, 32'h4D2, 32'h0,        4'h0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 32'h4D1, 32'hFFFFFFFF, 4'hF, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADAAEF, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 32'h1000, 32'h11111111, 4'hF, 32'h0,       1, 0));
        vecs.push_back(mk(0, 0, 32'h1000, 32'h0,       4'h0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFC, 32'h01234567, 4'hF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 32'hFFC, 32'h89ABCDEF, 4'h9, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'hFFC, 32'h0,        4'h0, 32'h892345EF, 0, 0));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADAAEF, 0, 5));
        vecs.push_back(mk(0, 0, 32'h4D0, 32'h0,        4'h0, 32'hDEADAAEF, 0, 0));
        // 0 wait states, base 0x2000, 16 words
        vecs.push_back(mk(1, 1, 32'h2000, 32'h11223344, 4'hF, 32'h0,       0, 0));
        vecs.push_back(mk(1, 0, 32'h2000, 32'h0,       4'h0, 32'h11223344, 0, 0));
        vecs.push_back(mk(1, 1, 32'h203C, 32'h55667788, 4'hF, 32'h0,       0, 0));
        vecs.push_back(mk(1, 0, 32'h203C, 32'h0,       4'h0, 32'h55667788, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1FFC, 32'h0,       4'h0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 1, 32'h1FFC, 32'hAAAAAAAA, 4'hF, 32'h0,       1, 0));
        vecs.push_back(mk(1, 0, 32'h2040, 32'h0,       4'h0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 1, 32'h2040, 32'h99999999, 4'hF, 32'h0,       1, 0));
        vecs.push_back(mk(1, 1, 32'h2002, 32'h77777777, 4'hF, 32'h0,       1, 0));
        vecs.push_back(mk(1, 0, 32'h2000, 32'h0,       4'h0, 32'h11223344, 0, 0));
        // 3 wait states
        vecs.push_back(mk(2, 1, 32'h8,   32'hA5A5A5A5, 4'hF, 32'h0,        0, 0));
        vecs.push_back(mk(2, 0, 32'h8,   32'h0,        4'h0, 32'hA5A5A5A5, 0, 0));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_req_ready d%0d", d), 32'(w_req_ready[d]), 32'd1);
            chk($sformatf("rst_rsp_valid d%0d", d), 32'(w_rsp_valid[d]), 32'd0);
            chk($sformatf("rst_rdata d%0d", d), w_rsp_rdata[d], 32'h0);
            chk($sformatf("rst_err d%0d", d), 32'(w_rsp_err[d]), 32'd0);
        end

        foreach (vecs[i]) do_req(vecs[i]);

        // Reset while a store is waiting: the store must be discarded.
        v_we = 1'b1; v_addr = 32'h8; v_wdata = 32'h12345678; v_mask = 4'hF;
        v_valid[2] = 1'b1;
        @(posedge clk); #1;
        v_valid[2] = 1'b0;
        chk("wait_rst_accepted", 32'(w_req_ready[2]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("wait_rst_ready", 32'(w_req_ready[2]), 32'd1);
        chk("wait_rst_valid", 32'(w_rsp_valid[2]), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("wait_rst_no_rsp", 32'(w_rsp_valid[2]), 32'd0);
        do_req(mk(2, 0, 32'h8, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 0));
        do_req(mk(2, 1, 32'h8, 32'hBEEF0000, 4'hC, 32'h0, 0, 0));
        do_req(mk(2, 0, 32'h8, 32'h0, 4'h0, 32'hBEEFA5A5, 0, 0));

        // Reset while a response is pending: the response is dropped.
        v_we = 1'b0; v_addr = 32'h4D0; v_mask = 4'h0;
        v_valid[0] = 1'b1;
        @(posedge clk); #1;
        v_valid[0] = 1'b0;
        n = 0;
        while (w_rsp_valid[0] !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_rst_pending", 32'(w_rsp_valid[0]), 32'd1);
        chk("resp_rst_rdata", w_rsp_rdata[0], 32'hDEADAAEF);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("resp_rst_valid", 32'(w_rsp_valid[0]), 32'd0);
        chk("resp_rst_ready", 32'(w_req_ready[0]), 32'd1);
        chk("resp_rst_rdata0", w_rsp_rdata[0], 32'h0);
        chk("resp_rst_err0", 32'(w_rsp_err[0]), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
